// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit core: opcode map, sequencer states and
// instruction field positions used by the controller and the ALU.
package cpu4_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_OR   = 4'h1,
        OP_AND  = 4'h2,
        OP_XOR  = 4'h3,
        OP_SUB  = 4'h4,
        OP_ADC  = 4'h5,
        OP_CMPA = 4'h6,
        OP_CMPB = 4'h7,
        OP_SHLA = 4'h8,
        OP_SHLB = 4'h9,
        OP_SHRA = 4'hA,
        OP_SHRB = 4'hB,
        OP_LDI  = 4'hC,
        OP_JMP  = 4'hD,
        OP_JZ   = 4'hE,
        OP_HLT  = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RA_HI  = 8;
    localparam int RA_LO  = 6;
    localparam int RB_HI  = 5;
    localparam int RB_LO  = 3;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;
    localparam int TGT_HI = 7;
    localparam int TGT_LO = 0;

    typedef struct packed {
        logic       is_alu;
        logic       is_ldi;
        logic       is_jmp;
        logic       is_jz;
        logic       is_hlt;
        logic [3:0] op;
        logic [2:0] rd;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [3:0] imm;
        logic [7:0] target;
    } dec_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= OP_SHRB);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: splits the IR into register fields,
// immediate, jump target and a one-hot instruction class.
module ctrl_decode
    import cpu4_pkg::*;
(
    input  logic [15:0] ir,
    output dec_t        dec
);

    // Field extraction and instruction classification
    always_comb begin
        dec        = '0;
        dec.op     = ir[OP_HI:OP_LO];
        dec.rd     = ir[RD_HI:RD_LO];
        dec.ra     = ir[RA_HI:RA_LO];
        dec.rb     = ir[RB_HI:RB_LO];
        dec.imm    = ir[IMM_HI:IMM_LO];
        dec.target = ir[TGT_HI:TGT_LO];
        case (op_e'(ir[OP_HI:OP_LO]))
            OP_LDI:  dec.is_ldi = 1'b1;
            OP_JMP:  dec.is_jmp = 1'b1;
            OP_JZ:   dec.is_jz  = 1'b1;
            OP_HLT:  dec.is_hlt = 1'b1;
            default: dec.is_alu = is_alu_op(ir[OP_HI:OP_LO]);
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute/writeback controller for the 4-bit core. Owns the
// program counter and the C/Z/S flag register.
module ctrl_sequencer
    import cpu4_pkg::*;
#(
    parameter int              PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = {PC_W{1'b0}}
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Run,
    output logic [PC_W-1:0] Instr_Addr,
    output logic            Instr_Rd_En,
    input  logic            Instr_Valid,
    input  logic [15:0]     Instr_Data,
    output logic [2:0]      Rf_Addr_A,
    output logic [2:0]      Rf_Addr_B,
    output logic [2:0]      Rf_Wr_Addr,
    output logic [3:0]      Rf_Wr_Data,
    output logic            Rf_Wr_En,
    output logic [3:0]      Alu_Opcode,
    output logic            Alu_Carry_In,
    input  logic [3:0]      Alu_Result,
    input  logic            Alu_Carry,
    input  logic            Alu_Zero,
    input  logic            Alu_Sign,
    output logic            Flag_C,
    output logic            Flag_Z,
    output logic            Flag_S,
    output logic            Halted
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_e          state_r;
    state_e          state_next_s;
    logic [PC_W-1:0] pc_r;
    logic [15:0]     ir_r;
    logic [3:0]      res_r;
    logic            flag_c_r;
    logic            flag_z_r;
    logic            flag_s_r;
    dec_t            dec_s;
    logic [PC_W-1:0] pc_inc_s;
    logic [PC_W-1:0] pc_tgt_s;
    logic            rd_en_s;
    logic            wr_en_s;
    logic            halted_s;

    ctrl_decode u_decode (
        .ir  (ir_r),
        .dec (dec_s)
    );

    assign pc_inc_s = pc_r + PC_ONE;
    assign pc_tgt_s = PC_W'(dec_s.target);

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; Run is only looked at while idle in FETCH
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FETCH:  state_next_s = Run ? ST_WAIT : ST_FETCH;
            ST_WAIT:   state_next_s = Instr_Valid ? ST_DECODE : ST_WAIT;
            ST_DECODE: state_next_s = dec_s.is_hlt ? ST_HALT : ST_EXEC;
            ST_EXEC:   state_next_s = (dec_s.is_alu || dec_s.is_ldi) ? ST_WB : ST_FETCH;
            ST_WB:     state_next_s = ST_FETCH;
            ST_HALT:   state_next_s = ST_HALT;
            default:   state_next_s = ST_FETCH;
        endcase
    end

    // Strobes decoded from state; the fetch pulse is suppressed while in reset
    always_comb begin
        rd_en_s  = 1'b0;
        wr_en_s  = 1'b0;
        halted_s = 1'b0;
        case (state_r)
            ST_FETCH: rd_en_s  = Run & ~Rst;
            ST_WB:    wr_en_s  = 1'b1;
            ST_HALT:  halted_s = 1'b1;
            default:  rd_en_s  = 1'b0;
        endcase
    end

    // IR capture, PC update, result and flag latching
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pc_r     <= RST_PC;
            ir_r     <= 16'h0000;
            res_r    <= 4'h0;
            flag_c_r <= 1'b0;
            flag_z_r <= 1'b0;
            flag_s_r <= 1'b0;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    if (Instr_Valid) begin
                        ir_r <= Instr_Data;
                    end
                end
                ST_EXEC: begin
                    if (dec_s.is_alu) begin
                        res_r    <= Alu_Result;
                        flag_c_r <= Alu_Carry;
                        flag_z_r <= Alu_Zero;
                        flag_s_r <= Alu_Sign;
                        pc_r     <= pc_inc_s;
                    end else if (dec_s.is_ldi) begin
                        res_r <= dec_s.imm;
                        pc_r  <= pc_inc_s;
                    end else if (dec_s.is_jmp) begin
                        pc_r <= pc_tgt_s;
                    end else if (dec_s.is_jz) begin
                        // Z here is still the value left by the previous instruction
                        pc_r <= flag_z_r ? pc_tgt_s : pc_inc_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                default: pc_r <= pc_r;
            endcase
        end
    end

    assign Instr_Addr   = pc_r;
    assign Instr_Rd_En  = rd_en_s;
    assign Rf_Addr_A    = dec_s.ra;
    assign Rf_Addr_B    = dec_s.rb;
    assign Alu_Opcode   = dec_s.is_alu ? dec_s.op : 4'h0;
    assign Rf_Wr_Addr   = dec_s.rd;
    assign Rf_Wr_Data   = res_r;
    assign Rf_Wr_En     = wr_en_s;
    assign Alu_Carry_In = flag_c_r;
    assign Flag_C       = flag_c_r;
    assign Flag_Z       = flag_z_r;
    assign Flag_S       = flag_s_r;
    assign Halted       = halted_s;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed program with literal
// expectations, then randomized traffic against an instruction-level model.
module tb_ctrl_sequencer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Run;
    logic [7:0]  Instr_Addr;
    logic        Instr_Rd_En;
    logic        Instr_Valid;
    logic [15:0] Instr_Data;
    logic [2:0]  Rf_Addr_A, Rf_Addr_B, Rf_Wr_Addr;
    logic [3:0]  Rf_Wr_Data;
    logic        Rf_Wr_En;
    logic [3:0]  Alu_Opcode;
    logic        Alu_Carry_In;
    logic [3:0]  Alu_Result;
    logic        Alu_Carry, Alu_Zero, Alu_Sign;
    logic        Flag_C, Flag_Z, Flag_S;
    logic        Halted;

    ctrl_sequencer #(.PC_W(8), .RST_PC(8'h00)) dut (
        .Clk(Clk), .Rst(Rst), .Run(Run),
        .Instr_Addr(Instr_Addr), .Instr_Rd_En(Instr_Rd_En),
        .Instr_Valid(Instr_Valid), .Instr_Data(Instr_Data),
        .Rf_Addr_A(Rf_Addr_A), .Rf_Addr_B(Rf_Addr_B),
        .Rf_Wr_Addr(Rf_Wr_Addr), .Rf_Wr_Data(Rf_Wr_Data), .Rf_Wr_En(Rf_Wr_En),
        .Alu_Opcode(Alu_Opcode), .Alu_Carry_In(Alu_Carry_In),
        .Alu_Result(Alu_Result), .Alu_Carry(Alu_Carry), .Alu_Zero(Alu_Zero),
        .Alu_Sign(Alu_Sign), .Flag_C(Flag_C), .Flag_Z(Flag_Z), .Flag_S(Flag_S),
        .Halted(Halted)
    );

    initial forever #5 Clk = ~Clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [15:0] mem [256];
    int          force_dly = 0;
    bit          alu_force = 1'b0;
    logic [3:0]  f_res = 4'h0;
    logic        f_c = 1'b0, f_z = 1'b0, f_s = 1'b0;
    bit          stray_en = 1'b0;
    int          stray_req = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory and ALU stand-in: answers each fetch after 0..3 extra cycles,
    // otherwise throws in stray Instr_Valid pulses with junk data
    initial begin
        logic       req_now;
        logic [7:0] addr_now, addr_p;
        bit         pending;
        int         dly;
        int         stray_done;
        pending = 1'b0; dly = 0; stray_done = 0;
        Instr_Valid = 1'b0; Instr_Data = 16'h0000;
        Alu_Result = 4'h0; Alu_Carry = 1'b0; Alu_Zero = 1'b0; Alu_Sign = 1'b0;
        forever begin
            @(negedge Clk);
            req_now  = Instr_Rd_En;
            addr_now = Instr_Addr;
            @(posedge Clk);
            #1;
            Instr_Valid = 1'b0;
            Instr_Data  = 16'($urandom);
            if (alu_force) begin
                Alu_Result = f_res; Alu_Carry = f_c; Alu_Zero = f_z; Alu_Sign = f_s;
            end else begin
                Alu_Result = 4'($urandom); Alu_Carry = 1'($urandom);
                Alu_Zero = 1'($urandom); Alu_Sign = 1'($urandom);
            end
            if (Rst) begin
                pending = 1'b0;
            end else begin
                if (req_now) begin
                    pending = 1'b1;
                    addr_p  = addr_now;
                    dly     = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 3));
                end
                if (pending) begin
                    if (dly == 0) begin
                        Instr_Valid = 1'b1;
                        Instr_Data  = mem[addr_p];
                        pending     = 1'b0;
                    end else begin
                        dly--;
                    end
                end else if (stray_req != stray_done) begin
                    Instr_Valid = 1'b1;
                    Instr_Data  = 16'hF000;
                    stray_done++;
                end else if (stray_en && $urandom_range(0, 5) == 0) begin
                    Instr_Valid = 1'b1;
                end
            end
        end
    end

    // Instruction-level reference: each accepted instruction word is retired on a
    // fixed timeline measured from the cycle its data was accepted (t_v)
    initial begin
        logic [7:0]  m_pc, p_pc;
        logic        m_c, m_z, m_s, p_c, p_z, p_s;
        logic [15:0] m_ir;
        logic [3:0]  m_res, op;
        bit          m_busy, m_wait, m_halt, m_wr, exp_rd, exp_wr, in_flight;
        int          t_v, apply_at;
        m_pc = 8'h00; m_c = 1'b0; m_z = 1'b0; m_s = 1'b0; m_ir = 16'h0000; m_res = 4'h0;
        m_busy = 1'b0; m_wait = 1'b0; m_halt = 1'b0; m_wr = 1'b0; t_v = -10; apply_at = -1;
        p_pc = 8'h00; p_c = 1'b0; p_z = 1'b0; p_s = 1'b0;
        forever begin
            @(negedge Clk);
            cyc++;
            if (Rst) begin
                m_pc = 8'h00; m_c = 1'b0; m_z = 1'b0; m_s = 1'b0; m_ir = 16'h0000; m_res = 4'h0;
                m_busy = 1'b0; m_wait = 1'b0; m_halt = 1'b0; m_wr = 1'b0; apply_at = -1;
                chk("rst_rd_en", Instr_Rd_En, 0);
                chk("rst_wr_en", Rf_Wr_En, 0);
                chk("rst_halted", Halted, 0);
                chk("rst_pc", Instr_Addr, 0);
                chk("rst_flags", {Flag_C, Flag_Z, Flag_S}, 0);
                chk("rst_rf_outs", {Rf_Addr_A, Rf_Addr_B, Rf_Wr_Addr, Rf_Wr_Data, Alu_Opcode}, 0);
            end else begin
                if (cyc == apply_at) begin
                    m_pc = p_pc; m_c = p_c; m_z = p_z; m_s = p_s;
                end
                op        = m_ir[15:12];
                in_flight = m_busy && !m_wait;
                exp_rd    = !m_busy && !m_halt && Run;
                exp_wr    = in_flight && m_wr && (cyc == t_v + 3);
                chk("rd_en", Instr_Rd_En, exp_rd);
                chk("wr_en", Rf_Wr_En, exp_wr);
                chk("halted", Halted, m_halt);
                chk("pc", Instr_Addr, m_pc);
                chk("flags", {Flag_C, Flag_Z, Flag_S}, {m_c, m_z, m_s});
                chk("carry_in", Alu_Carry_In, m_c);
                if (exp_wr) begin
                    chk("wr_addr", Rf_Wr_Addr, m_ir[11:9]);
                    chk("wr_data", Rf_Wr_Data, m_res);
                end
                if (in_flight && op <= 4'd11 && (cyc == t_v + 1 || cyc == t_v + 2)) begin
                    chk("alu_opcode", Alu_Opcode, op);
                    chk("rf_addr_a", Rf_Addr_A, m_ir[8:6]);
                    chk("rf_addr_b", Rf_Addr_B, m_ir[5:3]);
                end
                if (exp_rd) begin
                    m_busy = 1'b1;
                    m_wait = 1'b1;
                end else if (m_wait) begin
                    if (Instr_Valid) begin
                        m_wait = 1'b0;
                        m_ir   = Instr_Data;
                        t_v    = cyc;
                    end
                end else if (m_busy) begin
                    if (cyc == t_v + 1 && op == 4'hF) begin
                        m_halt = 1'b1;
                        m_busy = 1'b0;
                    end else if (cyc == t_v + 2) begin
                        p_c = m_c; p_z = m_z; p_s = m_s; p_pc = m_pc; m_wr = 1'b0;
                        if (op <= 4'd11) begin
                            m_res = Alu_Result; p_c = Alu_Carry; p_z = Alu_Zero; p_s = Alu_Sign;
                            p_pc = m_pc + 8'd1; m_wr = 1'b1;
                        end else if (op == 4'hC) begin
                            m_res = m_ir[3:0]; p_pc = m_pc + 8'd1; m_wr = 1'b1;
                        end else if (op == 4'hD) begin
                            p_pc = m_ir[7:0];
                        end else begin
                            p_pc = m_z ? m_ir[7:0] : m_pc + 8'd1;
                        end
                        apply_at = cyc + 1;
                        if (!m_wr) m_busy = 1'b0;
                    end else if (cyc == t_v + 3) begin
                        m_busy = 1'b0;
                    end
                end
            end
        end
    end

    // Waits (bounded) for the next fetch pulse, reporting cycles taken and writes seen
    task automatic wait_fetch(input string name, input logic [7:0] exp_addr, output int n,
                              output int wr_cnt, output logic [2:0] wa, output logic [3:0] wd);
        n = 0; wr_cnt = 0; wa = 3'd0; wd = 4'd0;
        do begin
            @(negedge Clk);
            n++;
            if (Rf_Wr_En) begin
                wr_cnt++; wa = Rf_Wr_Addr; wd = Rf_Wr_Data;
            end
        end while (!Instr_Rd_En && n < 60);
        chk({name, "_req"}, Instr_Rd_En, 1);
        chk({name, "_addr"}, Instr_Addr, exp_addr);
    endtask

    initial begin
        int         n, wc, cnt;
        logic [2:0] wa;
        logic [3:0] wd;
        Rst = 1'b1; Run = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        mem[8'h00] = 16'hC533;  // LDI R2,3
        mem[8'h01] = 16'h0298;  // ADD R1,R2,R3
        mem[8'h02] = 16'hE040;  // JZ 0x40
        mem[8'h40] = 16'h0298;
        mem[8'h41] = 16'hE010;  // JZ 0x10
        mem[8'h42] = 16'hD0FF;  // JMP 0xFF
        mem[8'hFF] = 16'hCE09;  // LDI R7,9
        repeat (3) @(negedge Clk);
        chk("reset_pc_literal", Instr_Addr, 8'h00);
        @(posedge Clk); #3;
        Rst = 1'b0; Run = 1'b1;

        wait_fetch("first", 8'h00, n, wc, wa, wd);
        wait_fetch("ldi", 8'h01, n, wc, wa, wd);
        chk("ldi_cycles", n, 5);
        chk("ldi_wr_cnt", wc, 1);
        chk("ldi_wr_addr", wa, 2);
        chk("ldi_wr_data", wd, 3);
        chk("ldi_flags", {Flag_C, Flag_Z, Flag_S}, 3'b000);

        alu_force = 1'b1; f_res = 4'h0; f_c = 1'b1; f_z = 1'b1; f_s = 1'b0;
        wait_fetch("add", 8'h02, n, wc, wa, wd);
        chk("add_cycles", n, 5);
        chk("add_wr_addr", wa, 1);
        chk("add_wr_data", wd, 0);
        chk("add_flags", {Flag_C, Flag_Z, Flag_S}, 3'b110);

        f_res = 4'h5; f_c = 1'b0; f_z = 1'b0; f_s = 1'b0;
        wait_fetch("jz_taken", 8'h40, n, wc, wa, wd);
        chk("jz_taken_cycles", n, 4);
        chk("jz_taken_wr", wc, 0);
        wait_fetch("alu2", 8'h41, n, wc, wa, wd);
        chk("alu2_wr_data", wd, 5);
        chk("alu2_flag_z", Flag_Z, 0);

        @(posedge Clk); #3;
        force_dly = 3;
        wait_fetch("jz_not_taken", 8'h42, n, wc, wa, wd);
        chk("jz_not_taken_cycles", n, 4);
        chk("jz_not_taken_wr", wc, 0);

        @(posedge Clk); #3;
        force_dly = 0; Run = 1'b0;
        @(posedge Clk); #3;
        @(posedge Clk); #3;
        Run = 1'b1;
        wait_fetch("jmp_delayed", 8'hFF, n, wc, wa, wd);
        chk("jmp_delayed_cycles", n, 5);
        chk("jmp_delayed_wr", wc, 0);

        wait_fetch("pc_wrap", 8'h00, n, wc, wa, wd);
        chk("pc_wrap_cycles", n, 5);
        chk("pc_wrap_wr_addr", wa, 7);
        chk("pc_wrap_wr_data", wd, 9);

        // Randomized traffic checked cycle by cycle against the model
        alu_force = 1'b0; force_dly = -1; stray_en = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        repeat (3000) begin
            @(posedge Clk); #3;
            Run = ($urandom_range(0, 7) != 0);
        end

        Run = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        n = 0;
        while (!Halted && n < 80) begin
            @(negedge Clk);
            n++;
        end
        chk("halt_seen", Halted, 1);
        cnt = 0;
        repeat (20) begin
            @(negedge Clk);
            if (Instr_Rd_En) cnt++;
        end
        chk("halt_no_fetch", cnt, 0);
        chk("halt_hold", Halted, 1);

        // Reset out of HALT, then reset again in the middle of a slow fetch
        stray_en = 1'b0; mem[8'h00] = 16'hC533;
        @(posedge Clk); #3;
        Rst = 1'b1; Run = 1'b0;
        @(posedge Clk); #3;
        @(posedge Clk); #3;
        Rst = 1'b0; Run = 1'b1; force_dly = 3;
        wait_fetch("restart", 8'h00, n, wc, wa, wd);
        chk("restart_unhalted", Halted, 0);
        @(posedge Clk); #3;
        Rst = 1'b1; Run = 1'b0; force_dly = 0;
        @(posedge Clk); #3;
        Rst = 1'b0;
        stray_req++;
        repeat (3) @(negedge Clk);
        chk("stray_halted", Halted, 0);
        chk("stray_pc", Instr_Addr, 8'h00);
        chk("stray_no_fetch", Instr_Rd_En, 0);
        @(posedge Clk); #3;
        Run = 1'b1;
        wait_fetch("after_stray", 8'h00, n, wc, wa, wd);
        wait_fetch("after_stray_ldi", 8'h01, n, wc, wa, wd);
        chk("after_stray_cycles", n, 5);
        chk("after_stray_wr_addr", wa, 2);
        chk("after_stray_wr_data", wd, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Multi-cycle fetch/decode/execute/writeback controller for the 4-bit core, sitting directly upstream of the ALU and register file. It fetches 16-bit instructions over a valid handshake and drives register-file read/write addresses and the ALU opcode. It latches the ALU result and flags, writes results back, and handles load-immediate, jump, conditional jump and halt. It owns the program counter and the architectural flag register (C, Z, S).

Parameters:
PC_W, 8, program counter / instruction address width
RST_PC, 8'h00, PC value loaded on reset

Ports:
Clk  in  1  single clock, rising edge
Rst  in  1  asynchronous, active-high reset
Run  in  1  level; 0 holds the sequencer in FETCH without issuing a read
Instr_Addr  out  PC_W  instruction fetch address (= PC)
Instr_Rd_En  out  1  one-cycle fetch request pulse
Instr_Valid  in  1  fetch data valid; honoured only in WAIT
Instr_Data  in  16  instruction word
Rf_Addr_A  out  3  register-file read address A (= Ra)
Rf_Addr_B  out  3  register-file read address B (= Rb)
Rf_Wr_Addr  out  3  write-back address (= Rd)
Rf_Wr_Data  out  4  write-back data
Rf_Wr_En  out  1  write strobe, one cycle
Alu_Opcode  out  4  ALU operation select
Alu_Carry_In  out  1  = Flag_C; consumed by ADC
Alu_Result  in  4  ALU result
Alu_Carry, Alu_Zero, Alu_Sign  in  1 each  ALU flag outputs
Flag_C, Flag_Z, Flag_S  out  1 each  architectural flags
Halted  out  1  high while in HALT

Behaviour:
- Instruction format: [15:12] Op, [11:9] Rd, [8:6] Ra, [5:3] Rb, [2:0] unused. LDI immediate = [3:0]. JMP/JZ target = [7:0].
- Op 0000-1011 are ALU ops (ADD, OR, AND, XOR, SUB, ADC, CMPA, CMPB, SHLA, SHLB, SHRA, SHRB), passed unchanged to Alu_Opcode. 1100 LDI, 1101 JMP, 1110 JZ, 1111 HLT.
- Async reset: state=FETCH, PC=RST_PC, IR=0, Flags=0, all strobes 0, Alu_Opcode=0, Rf_* outputs 0, Halted=0. Any in-flight fetch is abandoned; a late Instr_Valid is ignored because it is seen outside WAIT.
- FSM states: FETCH, WAIT, DECODE, EXEC, WB, HALT.
- FETCH: if Run=1, assert Instr_Rd_En for one cycle and go to WAIT. Otherwise stay, with no request.
- WAIT: stay until Instr_Valid=1; then IR<=Instr_Data and go to DECODE. There is no timeout.
- DECODE: drive Rf_Addr_A/B and Alu_Opcode from IR; these hold through EXEC. HLT goes to HALT.
- EXEC, ALU op: Res<=Alu_Result, {C,Z,S}<=Alu flags, PC<=PC+1, then WB.
- EXEC, LDI: Res<=imm, flags unchanged, PC<=PC+1, then WB.
- EXEC, JMP: PC<=target, then FETCH.
- EXEC, JZ: PC<=Flag_Z ? target : PC+1, then FETCH. JZ tests the flag value before this instruction's EXEC.
- WB: Rf_Wr_En=1 for exactly one cycle, with Rf_Wr_Addr=Rd and Rf_Wr_Data=Res. Then FETCH.
- HALT: absorbing; Halted=1 and no requests. Only Rst exits HALT.
- PC increment wraps from 2^PC_W-1 to 0. Jump targets are taken modulo 2^PC_W.
- Timing: ALU/LDI instructions with a 1-cycle memory take 5 cycles (FETCH, WAIT, DECODE, EXEC, WB). Jumps take 4 cycles.
- Run deassertion mid-instruction does not stall it; the instruction completes, and Run is sampled only in FETCH.
- Rf_Wr_En is never asserted outside WB.
- Instr_Rd_En is never asserted outside FETCH.

Decomposition:
- Shared package cpu4_pkg: Op encodings (the 12 ALU opcodes plus LDI/JMP/JZ/HLT), the state enum, and the instruction field bit positions. The ALU uses the same opcode constants.
- One sub-module, ctrl_decode: combinational IR-to-fields/class decode (is_alu, is_ldi, is_jmp, is_jz, is_hlt, Rd, Ra, Rb, imm, target).
- FSM, PC and flag register stay in ctrl_sequencer.

Test Plan:
- Reset, Run=1, memory returns 0xC53x (LDI R2,3) one cycle after the request -> Rf_Wr_En pulse with Addr=2 and Data=4'h3, five cycles after the first FETCH; PC=1; flags unchanged.
- ADD R1=R2+R3 with the ALU model returning 4'h0, Carry=1 -> Flag_C=1, Flag_Z=1, Flag_S=0; Rf_Wr_Data=0 written to R1.
- JZ 0x40 with Flag_Z=1 -> next Instr_Addr=0x40. With Flag_Z=0 -> next Instr_Addr=PC+1. No Rf_Wr_En in either case.
- PC=0xFF executing a non-jump -> next Instr_Addr=0x00.
- Instr_Valid delayed 3 cycles; Run toggled low during WAIT -> instruction completes; a single Instr_Rd_En pulse per instruction.
- HLT -> Halted=1 and no further Instr_Rd_En for 20 cycles. Rst asserted mid-WAIT of the next program, then a stray Instr_Valid arrives -> PC=0, state FETCH, the stray data is not latched.
